// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter feeding CHANNELS duty comparators,
// with shadow/active double-buffered registers that commit atomically at the period boundary.
module pwm_multi #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CENTER   = 0,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick,
  output logic                update_pending,
  output logic [WIDTH-1:0]    count_out
);

  logic [WIDTH-1:0]    shadow_period_q, shadow_period_d;
  logic [WIDTH-1:0]    active_period_q, active_period_d;
  logic [WIDTH-1:0]    shadow_duty_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_duty_d [CHANNELS];
  logic [WIDTH-1:0]    active_duty_q [CHANNELS];
  logic [WIDTH-1:0]    active_duty_d [CHANNELS];
  logic [WIDTH-1:0]    count_q, count_d;
  logic                dir_up_q, dir_up_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                tick_q, tick_d;
  logic                pending_q, pending_d;

  logic             wr_valid;
  logic             boundary;
  logic             commit;
  logic [WIDTH-1:0] top_active;
  logic [WIDTH-1:0] top_shadow;

  assign wr_valid = wr_en && (wr_addr <= ADDR_W'(CHANNELS));
  assign boundary = (count_q == '0);
  assign commit   = enable && boundary && pending_q;

  // A programmed period of 0 behaves as 1, so TOP = Pe-1 never underflows.
  assign top_active = (active_period_q == '0) ? '0 : active_period_q - WIDTH'(1);
  assign top_shadow = (shadow_period_q == '0) ? '0 : shadow_period_q - WIDTH'(1);

  always_comb begin
    shadow_period_d = shadow_period_q;
    shadow_duty_d   = shadow_duty_q;
    if (wr_en && (wr_addr == '0)) shadow_period_d = wr_data;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (wr_en && (wr_addr == ADDR_W'(c + 1))) shadow_duty_d[c] = wr_data;
    end
  end

  always_comb begin
    active_period_d = active_period_q;
    active_duty_d   = active_duty_q;
    count_d         = count_q;
    dir_up_d        = dir_up_q;
    pending_d       = pending_q;
    if (!enable) begin
      active_period_d = shadow_period_q;
      active_duty_d   = shadow_duty_q;
      pending_d       = 1'b0;
      count_d         = (CENTER != 0) ? '0 : top_shadow;
      dir_up_d        = 1'b1;
    end else begin
      // A write landing on the commit edge wins the pending flag for the next boundary.
      if (wr_valid)    pending_d = 1'b1;
      else if (commit) pending_d = 1'b0;

      if (commit) begin
        active_period_d = shadow_period_q;
        active_duty_d   = shadow_duty_q;
        count_d         = (CENTER != 0) ? '0 : top_shadow;
        dir_up_d        = 1'b1;
      end else if (CENTER == 0) begin
        count_d = boundary ? top_active : count_q - WIDTH'(1);
      end else if (boundary) begin
        count_d  = (top_active == '0) ? '0 : WIDTH'(1);
        dir_up_d = 1'b1;
      end else if (count_q >= top_active) begin
        count_d  = count_q - WIDTH'(1);
        dir_up_d = 1'b0;
      end else begin
        count_d = dir_up_q ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
  end

  always_comb begin
    tick_d = enable && boundary;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      pwm_d[c] = enable && (count_q < active_duty_q[c]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_period_q <= '0;
      active_period_q <= '0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        shadow_duty_q[c] <= '0;
        active_duty_q[c] <= '0;
      end
      count_q   <= '0;
      dir_up_q  <= 1'b1;
      pwm_q     <= '0;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      shadow_period_q <= shadow_period_d;
      active_period_q <= active_period_d;
      shadow_duty_q   <= shadow_duty_d;
      active_duty_q   <= active_duty_d;
      count_q         <= count_d;
      dir_up_q        <= dir_up_d;
      pwm_q           <= pwm_d;
      tick_q          <= tick_d;
      pending_q       <= pending_d;
    end
  end

  assign pwm_out        = pwm_q;
  assign period_tick    = tick_q;
  assign update_pending = pending_q;
  assign count_out      = count_q;

endmodule
